// File: rtl/cnn_job_sched.sv
// cnn_job_sched
//   Job queue and dispatcher for the CNN accelerator. Commands {id, sel} are
//   queued in a QDEPTH-deep FIFO and dispatched one at a time, strictly in
//   FIFO order. A dispatched job pulses job_start and then waits for all of
//   its selected engines to report done. The job also ends on a DMA error or
//   when its timeout expires. Each job then returns one response word on the
//   resp_* handshake.
//
// Ports
//   clk, rst_b              clock, asynchronous active-low reset
//   cmd_valid/ready/id/sel  job request channel (ready = queue not full)
//   flush                   drop every queued, undispatched job
//   tmo_limit               per-job timeout in cycles (0 = no timeout)
//   job_start/sel/id        engine dispatch (one-cycle start pulse)
//   eng_done, dma_err       per-engine done pulses, DMA error pulse
//   resp_valid/ready/id/data response channel to cop_agent
//   busy, q_count           activity flag, occupied queue entries
//
// Response word: [7:0] status (0 OK, 1 DMA_ERR, 2 TIMEOUT, 3 BAD_SEL),
//   [15:8] mask of completed engines, [16 +: TMO_WIDTH] elapsed RUN cycles.
//
// state   | meaning
// S_IDLE  | waiting; pops the queue head when one is present
// S_DISP  | popped job latched; reject empty engine mask or dispatch
// S_START | job_start pulse, arm pending mask and elapsed counter
// S_RUN   | waiting for engine completion, DMA error or timeout
// S_RESP  | response held until resp_ready

module cnn_job_sched #(
   parameter int ID_WIDTH        = 12,
   parameter int NUM_ENG         = 4,
   parameter int QDEPTH          = 4,
   parameter int TMO_WIDTH       = 20,
   parameter int RESP_DATA_WIDTH = 64
) (
   input  logic                       clk,
   input  logic                       rst_b,
   input  logic                       cmd_valid,
   output logic                       cmd_ready,
   input  logic [ID_WIDTH-1:0]        cmd_id,
   input  logic [NUM_ENG-1:0]         cmd_sel,
   input  logic                       flush,
   input  logic [TMO_WIDTH-1:0]       tmo_limit,
   output logic                       job_start,
   output logic [NUM_ENG-1:0]         job_sel,
   output logic [ID_WIDTH-1:0]        job_id,
   input  logic [NUM_ENG-1:0]         eng_done,
   input  logic                       dma_err,
   output logic                       resp_valid,
   input  logic                       resp_ready,
   output logic [ID_WIDTH-1:0]        resp_id,
   output logic [RESP_DATA_WIDTH-1:0] resp_data,
   output logic                       busy,
   output logic [$clog2(QDEPTH):0]    q_count
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] ST_OK      = 2'd0;
   localparam logic [1:0] ST_DMA_ERR = 2'd1;
   localparam logic [1:0] ST_TIMEOUT = 2'd2;
   localparam logic [1:0] ST_BAD_SEL = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_DISP,
      S_START,
      S_RUN,
      S_RESP
   } state_t;

   state_t state, state_nxt;

   logic [ID_WIDTH-1:0]  q_id  [QDEPTH];
   logic [NUM_ENG-1:0]   q_sel [QDEPTH];
   logic [PW-1:0]        wr_ptr, rd_ptr;
   logic [CW-1:0]        count;
   logic                 rdy_en;
   logic                 push, pop;

   logic [ID_WIDTH-1:0]  cur_id;
   logic [NUM_ENG-1:0]   cur_sel;
   logic [NUM_ENG-1:0]   pending, pending_nxt;
   logic [TMO_WIDTH-1:0] elapsed, elapsed_inc;
   logic                 tmo_hit;

   logic                 ld_resp;
   logic [1:0]           resp_st_nxt;
   logic [1:0]           resp_st;
   logic [NUM_ENG-1:0]   resp_mask;
   logic [TMO_WIDTH-1:0] resp_elp;

   // cmd_ready is gated by a flop so it stays low throughout reset and
   // rises only on the first clock after release.
   assign cmd_ready = rdy_en && (count != CW'(QDEPTH));
   assign push      = cmd_valid && cmd_ready && !flush;
   assign q_count   = count;
   assign busy      = (state != S_IDLE) || (count != '0);
   assign job_start = (state == S_START);
   assign resp_valid = (state == S_RESP);

   assign pending_nxt = pending & ~eng_done;
   assign elapsed_inc = (&elapsed) ? elapsed : elapsed + TMO_WIDTH'(1);
   // elapsed_inc is this cycle's count of RUN cycles, so the timeout fires
   // on the tmo_limit-th RUN cycle; saturation keeps the compare true.
   assign tmo_hit     = (tmo_limit != '0) && (elapsed_inc >= tmo_limit);

   always_ff @(posedge clk) begin
      if (push) begin
         q_id[wr_ptr]  <= cmd_id;
         q_sel[wr_ptr] <= cmd_sel;
      end
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         rdy_en <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
               2'b10:   count <= count + CW'(1);
               2'b01:   count <= count - CW'(1);
               default: count <= count;
            endcase
         end
      end
   end

   always_comb begin
      state_nxt   = state;
      pop         = 1'b0;
      ld_resp     = 1'b0;
      resp_st_nxt = ST_OK;
      case (state)
         S_IDLE: begin
            // flush wins over a pop so a flushed head is never dispatched
            if (count != '0 && !flush) begin
               pop       = 1'b1;
               state_nxt = S_DISP;
            end
         end
         S_DISP: begin
            if (cur_sel == '0) begin
               ld_resp     = 1'b1;
               resp_st_nxt = ST_BAD_SEL;
               state_nxt   = S_RESP;
            end else begin
               state_nxt = S_START;
            end
         end
         S_START: state_nxt = S_RUN;
         S_RUN: begin
            if (dma_err) begin
               ld_resp     = 1'b1;
               resp_st_nxt = ST_DMA_ERR;
               state_nxt   = S_RESP;
            end else if (pending_nxt == '0) begin
               ld_resp     = 1'b1;
               resp_st_nxt = ST_OK;
               state_nxt   = S_RESP;
            end else if (tmo_hit) begin
               ld_resp     = 1'b1;
               resp_st_nxt = ST_TIMEOUT;
               state_nxt   = S_RESP;
            end
         end
         S_RESP: begin
            if (resp_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state     <= S_IDLE;
         cur_id    <= '0;
         cur_sel   <= '0;
         job_id    <= '0;
         job_sel   <= '0;
         pending   <= '0;
         elapsed   <= '0;
         resp_id   <= '0;
         resp_st   <= ST_OK;
         resp_mask <= '0;
         resp_elp  <= '0;
      end else begin
         state <= state_nxt;
         if (pop) begin
            cur_id  <= q_id[rd_ptr];
            cur_sel <= q_sel[rd_ptr];
         end
         if (state == S_DISP && cur_sel != '0) begin
            job_id  <= cur_id;
            job_sel <= cur_sel;
         end
         if (state == S_START) begin
            pending <= cur_sel;
            elapsed <= '0;
         end
         if (state == S_RUN) begin
            pending <= pending_nxt;
            elapsed <= elapsed_inc;
         end
         if (ld_resp) begin
            resp_id <= cur_id;
            resp_st <= resp_st_nxt;
            if (state == S_RUN) begin
               resp_mask <= cur_sel & ~pending_nxt;
               resp_elp  <= elapsed_inc;
            end else begin
               resp_mask <= '0;
               resp_elp  <= '0;
            end
         end
      end
   end

   always_comb begin
      resp_data                  = '0;
      resp_data[1:0]             = resp_st;
      resp_data[8 +: NUM_ENG]    = resp_mask;
      resp_data[16 +: TMO_WIDTH] = resp_elp;
   end

endmodule

// File: doc/cnn_job_sched.md
Name: cnn_job_sched

Overview:
Multi-job command queue and dispatcher for the CNN accelerator. It generalises single-job start/complete tracking to a QDEPTH-deep job FIFO and NUM_ENG engine-select bits. It adds a per-job timeout, DMA error capture and a status/elapsed-cycle response word. It sits between the command decoder and the engine/DMA start and done signals, and drives the response channel to cop_agent.

Parameters:
ID_WIDTH, 12, job/response ID width
NUM_ENG, 4, number of engines selectable per job (1..8)
QDEPTH, 4, job FIFO depth; power of two, >=2
TMO_WIDTH, 20, timeout and elapsed counter width
RESP_DATA_WIDTH, 64, response data width; must be >= 16+TMO_WIDTH

Ports:
clk  in  1  clock
rst_b  in  1  asynchronous active-low reset
cmd_valid  in  1  job request valid
cmd_ready  out  1  queue can accept (= !full)
cmd_id  in  ID_WIDTH  job ID
cmd_sel  in  NUM_ENG  engines the job uses
flush  in  1  drop all queued, undispatched jobs
tmo_limit  in  TMO_WIDTH  timeout in cycles; 0 disables timeout
job_start  out  1  one-cycle engine start pulse
job_sel  out  NUM_ENG  engine mask of the dispatched job
job_id  out  ID_WIDTH  ID of the dispatched job
eng_done  in  NUM_ENG  per-engine done pulses
dma_err  in  1  DMA error pulse
resp_valid  out  1  response valid
resp_ready  in  1  response accepted
resp_id  out  ID_WIDTH  ID of the completed job
resp_data  out  RESP_DATA_WIDTH  status word
busy  out  1  FSM not IDLE or queue non-empty
q_count  out  $clog2(QDEPTH)+1  occupied queue entries

Behaviour:
- Reset: all outputs 0, queue empty, FSM in IDLE. cmd_ready rises the first cycle after reset deassertion. Reset mid-job abandons the job silently: no response and no job_start.
- Queue: FIFO of {id, sel}. A push occurs on cmd_valid && cmd_ready. cmd_ready = (q_count != QDEPTH). There is no bypass, so push and pop in the same cycle are legal and q_count is unchanged.
- Flush: empties the queue in one cycle and overrides a same-cycle push (that command is lost). A running job is unaffected.
- FSM IDLE:
  - Queue non-empty -> pop head. A head with sel == 0 goes to RESP with status BAD_SEL and no job_start. Otherwise it goes to START.
- FSM START:
  - job_start = 1 for exactly this cycle; job_sel and job_id hold the popped values until the next dispatch.
  - pending <= sel; elapsed <= 0; next state RUN.
- FSM RUN:
  - elapsed increments each cycle, saturating at all-ones.
  - pending &= ~eng_done; done pulses on unselected engines are ignored but still recorded nowhere.
  - Exit priority, evaluated each cycle on the current inputs:
    - dma_err -> DMA_ERR.
    - (pending & ~eng_done) == 0 -> OK.
    - tmo_limit != 0 && elapsed+1 >= tmo_limit -> TIMEOUT.
  - On exit, resp_valid = 1 on the next cycle (state RESP).
- FSM RESP:
  - resp_valid is held, with stable resp_id and resp_data, until resp_ready. Then -> IDLE, resp_valid = 0.
- Latency: a push into an empty, idle queue at edge N gives job_start high in the cycle after edge N+2 (two-cycle minimum).
- Response word fields:
  - resp_data[7:0] = status: 0 OK, 1 DMA_ERR, 2 TIMEOUT, 3 BAD_SEL.
  - resp_data[15:8] = sel & ~pending_final, zero-extended: the engines that completed.
  - resp_data[16+TMO_WIDTH-1:16] = elapsed cycles, with elapsed = 1 on the first RUN cycle.
  - All remaining bits are 0. For BAD_SEL the mask and elapsed fields are 0.
- busy = (state != IDLE) || (q_count != 0).
- Only one job is in flight at a time. Jobs are dispatched strictly in FIFO order.

Test Plan:
- Push id=5, sel=4'b0011; eng_done[0] pulses 3 cycles after job_start and eng_done[1] 6 cycles after -> job_start once with job_sel=0011 and job_id=5; resp_id=5, status 0, mask 0x03, elapsed 6.
- Push 5 jobs back-to-back with QDEPTH=4 and the FSM stalled in RESP (resp_ready=0) -> cmd_ready drops when q_count=4. Responses come out in push order, one per resp_ready handshake.
- tmo_limit=10, sel=0001, no eng_done -> status 2, mask 0x00, elapsed 10, resp_valid 1 cycle after the 10th RUN cycle.
- eng_done completing the job in the same cycle as dma_err -> status 1. Separately, completion on the same cycle as the timeout -> status 0.
- Push sel=0 id=7 -> no job_start; resp status 3, id 7. Then flush with 3 queued jobs during RUN -> current job responds, q_count=0, and no further job_start.
- Assert rst_b low during RUN with 2 queued jobs -> all outputs 0 immediately, q_count=0, and no response after release.
